cond_fork4_feeder: RTL

- Clocked source stage that sits directly upstream of the 4-way conditional-fork micropipeline stage.
- Accepts a word plus a 4-bit branch mask on a valid/ready interface.
- Turns each word into one drive pulse with per-branch valid bits and holds the data stable (bundled-data).
- Waits for the fork's returned free event, synchronized into clk, before accepting the next word.

---
 rtl/cond_fork4_feeder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/cond_fork4_feeder.sv
`default_nettype none
// =============================================================================
// Module : cond_fork4_feeder
// Clocked bundled-data source for a 4-way conditional fork stage.
// Rev    : 1.0
// =============================================================================
module cond_fork4_feeder #(
   parameter int DATA_W      = 32,
   parameter int DRIVE_CYC   = 2,
   parameter int TIMEOUT_CYC = 1024,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [3:0]        in_mask,
   output logic              o_drive,
   output logic [3:0]        o_valid,
   output logic [DATA_W-1:0] o_data,
   input  logic              i_free,
   output logic              o_busy,
   output logic              o_timeout,
   output logic [CNT_W-1:0]  o_sent_cnt,
   output logic [CNT_W-1:0]  o_drop_cnt
);

   localparam int                  c_WAIT_W   = $clog2(TIMEOUT_CYC + 2);
   localparam logic [c_WAIT_W-1:0] c_WAIT_LIM = c_WAIT_W'(TIMEOUT_CYC);
   localparam logic [3:0]          c_DRV_LAST = 4'(DRIVE_CYC - 1);

   localparam logic [1:0] c_IDLE      = 2'd0;
   localparam logic [1:0] c_DRIVE     = 2'd1;
   localparam logic [1:0] c_WAIT_FREE = 2'd2;

   logic [1:0]          r_state;
   logic [1:0]          w_next_state;
   logic                r_live;
   logic                r_free_s1;
   logic                r_free_s2;
   logic                r_free_s3;
   logic                r_free_seen;
   logic [3:0]          r_drv_cnt;
   logic [c_WAIT_W-1:0] r_wait;

   logic                w_free_evt;
   logic                w_accept;
   logic                w_take;
   logic                w_drop;
   logic                w_drv_done;
   logic                w_drive_nxt;
   logic                w_busy_nxt;
   logic                w_timeout_nxt;
   logic                w_free_seen_nxt;
   logic [3:0]          w_valid_nxt;
   logic [3:0]          w_drv_cnt_nxt;
   logic [DATA_W-1:0]   w_data_nxt;
   logic [c_WAIT_W-1:0] w_wait_nxt;

   // r_live keeps in_ready low until the first clock after reset release.
   assign in_ready   = r_live & (r_state == c_IDLE);
   assign w_accept   = in_valid & in_ready;
   assign w_take     = w_accept & (|in_mask);
   assign w_drop     = w_accept & ~(|in_mask);
   assign w_free_evt = r_free_s2 & ~r_free_s3;
   assign w_drv_done = (r_state == c_DRIVE) && (r_drv_cnt == c_DRV_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_take) begin
               w_next_state = c_DRIVE;
            end
         end
         c_DRIVE: begin
            if (w_drv_done) begin
               w_next_state = c_WAIT_FREE;
            end
         end
         c_WAIT_FREE: begin
            if (r_free_seen || w_free_evt) begin
               w_next_state = c_IDLE;
            end
         end
         default: w_next_state = c_IDLE;
      endcase
   end

   // Output values are computed from the next state so every output leaves a flop.
   always_comb begin
      w_drive_nxt = (w_next_state == c_DRIVE);
      w_busy_nxt  = (w_next_state != c_IDLE);
      w_valid_nxt = 4'd0;
      if (w_drive_nxt) begin
         w_valid_nxt = w_take ? in_mask : o_valid;
      end
      w_data_nxt    = w_take ? in_data : o_data;
      w_drv_cnt_nxt = (r_state == c_DRIVE) ? r_drv_cnt + 4'd1 : 4'd0;
      if (r_state != c_WAIT_FREE) begin
         w_wait_nxt = c_WAIT_W'(1);
      end else if (r_wait == c_WAIT_LIM) begin
         w_wait_nxt = r_wait;
      end else begin
         w_wait_nxt = r_wait + 1'b1;
      end
      w_free_seen_nxt = r_free_seen;
      if (w_take) begin
         w_free_seen_nxt = 1'b0;
      end else if ((r_state == c_DRIVE) && w_free_evt) begin
         w_free_seen_nxt = 1'b1;
      end
      w_timeout_nxt = o_timeout;
      if ((TIMEOUT_CYC != 0) && (w_next_state == c_WAIT_FREE) && (w_wait_nxt == c_WAIT_LIM)) begin
         w_timeout_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live      <= 1'b0;
         r_free_s1   <= 1'b0;
         r_free_s2   <= 1'b0;
         r_free_s3   <= 1'b0;
         r_free_seen <= 1'b0;
         r_drv_cnt   <= 4'd0;
         r_wait      <= '0;
         o_drive     <= 1'b0;
         o_valid     <= 4'd0;
         o_data      <= '0;
         o_busy      <= 1'b0;
         o_timeout   <= 1'b0;
         o_sent_cnt  <= '0;
         o_drop_cnt  <= '0;
      end else begin
         r_live      <= 1'b1;
         r_free_s1   <= i_free;
         r_free_s2   <= r_free_s1;
         r_free_s3   <= r_free_s2;
         r_free_seen <= w_free_seen_nxt;
         r_drv_cnt   <= w_drv_cnt_nxt;
         r_wait      <= w_wait_nxt;
         o_drive     <= w_drive_nxt;
         o_valid     <= w_valid_nxt;
         o_data      <= w_data_nxt;
         o_busy      <= w_busy_nxt;
         o_timeout   <= w_timeout_nxt;
         if (w_drv_done) begin
            o_sent_cnt <= o_sent_cnt + 1'b1;
         end
         if (w_drop) begin
            o_drop_cnt <= o_drop_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
